// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Fetch/execute sequencing FSM for the 19-bit CPU. It steps through
// CLEAR -> FETCH -> EXEC -> UPDATE, handshakes with instruction memory,
// latches the fetched word into ir, starts the execution unit and, once the
// instruction retires, issues exactly one PC command (CLEAR / INCR / LOAD) or
// halts.
//
// Every output is registered. The combinational block works out the next
// state and the command for that state, and the output registers capture
// them at the same edge that moves the state register. Each output therefore
// describes the state the FSM is currently in (Moore).
//
// Optional feature (compile-time macro):
//   PC_SEQ_INSTR_CNT_EN - when defined, instr_count counts retired
//                         instructions. It advances at the end of each UPDATE
//                         cycle and clears on reset and on entry to CLEAR.
//                         When undefined, the counter is omitted and
//                         instr_count is tied to 0.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   start          in   begin/restart execution (honoured in IDLE/HALT only)
//   halt_req       in   external halt, sampled when an instruction retires
//   imem_req       out  instruction fetch request, held until imem_ack
//   imem_ack       in   fetch data valid
//   imem_rdata     in   fetched instruction word
//   ir             out  latched instruction register
//   exec_start     out  one-cycle pulse on the first EXEC cycle
//   exec_done      in   execution unit finished the current instruction
//   jump_req       in   with exec_done: redirect the PC
//   dec_halt       in   with exec_done: instruction is HALT
//   jump_target    in   with exec_done: redirect address
//   LOAD_REG       out  PC control: load enable
//   INC_PC         out  PC control: increment/clear select
//   LOAD_SELECT    out  PC control: register select
//   pc_in_address  out  address presented to the PC load input
//   state_dbg      out  current state encoding
//   instr_count    out  retired-instruction count
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                ADDR_W   = 19,
    parameter int                INSTR_W  = 19,
    parameter int                SEL_W    = 3,
    parameter logic [SEL_W-1:0]  SEL_PC   = 3'd0,
    parameter logic [SEL_W-1:0]  SEL_NONE = 3'd7
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               start,
    input  logic               halt_req,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic               jump_req,
    input  logic               dec_halt,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               LOAD_REG,
    output logic               INC_PC,
    output logic [SEL_W-1:0]   LOAD_SELECT,
    output logic [ADDR_W-1:0]  pc_in_address,
    output logic [2:0]         state_dbg,
    output logic [31:0]        instr_count
);

    // State codes are visible on state_dbg, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // PC command to be shown during the next cycle.
    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_INCR,
        CMD_LOAD
    } cmd_t;

    state_t state;
    state_t next_state;
    cmd_t   next_cmd;
    logic   ir_load;     // fetch handshake completes this cycle
    logic   jump_load;   // retiring instruction redirects the PC

    // ------------------------------------------------------------------
    // Next-state / next-command logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        next_state = state;
        next_cmd   = CMD_NONE;
        ir_load    = 1'b0;
        jump_load  = 1'b0;

        case (state)
            ST_IDLE, ST_HALT: begin
                // Both resting states restart from address 0.
                if (start) begin
                    next_state = ST_CLEAR;
                    next_cmd   = CMD_CLEAR;
                end
            end

            ST_CLEAR: begin
                next_state = ST_FETCH;
            end

            ST_FETCH: begin
                // No timeout: memory may stall for as long as it needs.
                if (imem_ack) begin
                    next_state = ST_EXEC;
                    ir_load    = 1'b1;
                end
            end

            ST_EXEC: begin
                // jump_req / jump_target / halts only mean something with
                // exec_done. Halt wins over jump, and a halted instruction
                // leaves the PC alone.
                if (exec_done) begin
                    if (halt_req || dec_halt) begin
                        next_state = ST_HALT;
                    end else if (jump_req) begin
                        next_state = ST_UPDATE;
                        next_cmd   = CMD_LOAD;
                        jump_load  = 1'b1;
                    end else begin
                        next_state = ST_UPDATE;
                        next_cmd   = CMD_INCR;
                    end
                end
            end

            ST_UPDATE: begin
                next_state = ST_FETCH;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers sample their inputs from the same edge, whatever order
        // the blocks run in.
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Registered control outputs
    //
    // Loaded from next_state/next_cmd, so the command is on the PC pins
    // for exactly the one CLEAR or UPDATE cycle that it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            imem_req    <= 1'b0;
            exec_start  <= 1'b0;
            LOAD_REG    <= 1'b0;
            INC_PC      <= 1'b0;
            LOAD_SELECT <= SEL_NONE;
        end else begin
            imem_req    <= (next_state == ST_FETCH);
            exec_start  <= ir_load;
            LOAD_REG    <= (next_cmd == CMD_LOAD);
            INC_PC      <= (next_cmd == CMD_INCR);
            LOAD_SELECT <= (next_cmd == CMD_NONE) ? SEL_NONE : SEL_PC;
        end
    end

    // ------------------------------------------------------------------
    // Instruction register and jump address
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: these datapath registers are reset because their values are
        // visible on ports and must be 0 after reset. A plain storage array
        // with no such visibility would be left without a reset.
        if (!RESET_N) begin
            ir            <= '0;
            pc_in_address <= '0;
        end else begin
            if (ir_load) begin
                ir <= imem_rdata;
            end
            // Only a taken jump changes the address. Between jumps it keeps
            // the last target, which the PC ignores unless LOAD_REG is high.
            if (jump_load) begin
                pc_in_address <= jump_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter (optional)
    // ------------------------------------------------------------------
`ifdef PC_SEQ_INSTR_CNT_EN
    logic [31:0] instr_count_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instr_count_q <= '0;
        end else if (next_state == ST_CLEAR) begin
            instr_count_q <= '0;
        end else if (state == ST_UPDATE) begin
            // Wraps naturally from 32'hFFFF_FFFF to 0.
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign instr_count = instr_count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. The stimulus is a table of per-cycle
// records, each holding the inputs for one cycle and the outputs expected
// after the next rising edge. A record's inputs are driven on the falling
// edge, its expected outputs go into a scoreboard queue, and one cycle later
// they are popped and compared against the DUT. Hand-written sections cover
// the reset value, the ten-instruction count and an asynchronous reset in
// the middle of a fetch.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int ADDR_W  = 19;
    localparam int INSTR_W = 19;
    localparam int SEL_W   = 3;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_FET  = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;
    localparam logic [2:0] S_HLT  = 3'd5;

    localparam logic [2:0] SP = 3'd0;   // SEL_PC
    localparam logic [2:0] SN = 3'd7;   // SEL_NONE

    typedef struct packed {
        logic               start;
        logic               halt_req;
        logic               ack;
        logic [INSTR_W-1:0] rdata;
        logic               done;
        logic               jr;
        logic               dh;
        logic [ADDR_W-1:0]  jt;
    } in_t;

    typedef struct packed {
        logic [2:0]         state;
        logic               req;
        logic               xs;
        logic               lr;
        logic               inc;
        logic [2:0]         sel;
        logic [INSTR_W-1:0] ir;
        logic [ADDR_W-1:0]  pca;
        logic [31:0]        cnt;   // value when the counter is compiled in
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    // DUT signals
    logic               CLK = 1'b0;
    logic               RESET_N = 1'b0;
    logic               start = 1'b0;
    logic               halt_req = 1'b0;
    logic               imem_req;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [INSTR_W-1:0] ir;
    logic               exec_start;
    logic               exec_done = 1'b0;
    logic               jump_req = 1'b0;
    logic               dec_halt = 1'b0;
    logic [ADDR_W-1:0]  jump_target = '0;
    logic               LOAD_REG;
    logic               INC_PC;
    logic [SEL_W-1:0]   LOAD_SELECT;
    logic [ADDR_W-1:0]  pc_in_address;
    logic [2:0]         state_dbg;
    logic [31:0]        instr_count;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    vec_t tbl[24];

    pc_sequencer dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .start         (start),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ir            (ir),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .jump_req      (jump_req),
        .dec_halt      (dec_halt),
        .jump_target   (jump_target),
        .LOAD_REG      (LOAD_REG),
        .INC_PC        (INC_PC),
        .LOAD_SELECT   (LOAD_SELECT),
        .pc_in_address (pc_in_address),
        .state_dbg     (state_dbg),
        .instr_count   (instr_count)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef PC_SEQ_INSTR_CNT_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    function automatic in_t mi(input logic st, input logic hr, input logic ack,
                               input logic [INSTR_W-1:0] rd, input logic dn,
                               input logic jr, input logic dh,
                               input logic [ADDR_W-1:0] jt);
        in_t r;
        r.start = st; r.halt_req = hr; r.ack = ack; r.rdata = rd;
        r.done = dn;  r.jr = jr;       r.dh = dh;   r.jt = jt;
        return r;
    endfunction

    function automatic exp_t me(input logic [2:0] s, input logic req,
                                input logic xs, input logic lr, input logic inc,
                                input logic [2:0] sel,
                                input logic [INSTR_W-1:0] irv,
                                input logic [ADDR_W-1:0] pca,
                                input logic [31:0] cnt);
        exp_t r;
        r.state = s; r.req = req; r.xs = xs; r.lr = lr; r.inc = inc;
        r.sel = sel; r.ir = irv;  r.pca = pca; r.cnt = cnt;
        return r;
    endfunction

    function automatic vec_t mv(input in_t i, input exp_t e);
        vec_t r;
        r.i = i;
        r.e = e;
        return r;
    endfunction

    task automatic drive(input in_t i);
        start       = i.start;
        halt_req    = i.halt_req;
        imem_ack    = i.ack;
        imem_rdata  = i.rdata;
        exec_done   = i.done;
        jump_req    = i.jr;
        dec_halt    = i.dh;
        jump_target = i.jt;
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".state"},       64'(state_dbg),     64'(e.state));
        check({tag, ".imem_req"},    64'(imem_req),      64'(e.req));
        check({tag, ".exec_start"},  64'(exec_start),    64'(e.xs));
        check({tag, ".LOAD_REG"},    64'(LOAD_REG),      64'(e.lr));
        check({tag, ".INC_PC"},      64'(INC_PC),        64'(e.inc));
        check({tag, ".LOAD_SELECT"}, 64'(LOAD_SELECT),   64'(e.sel));
        check({tag, ".ir"},          64'(ir),            64'(e.ir));
        check({tag, ".pc_in_addr"},  64'(pc_in_address), 64'(e.pca));
        check({tag, ".instr_count"}, 64'(instr_count),   64'(cnt_exp(e.cnt)));
    endtask

    // Called on a falling edge: drive, queue the expectation, compare on the
    // next falling edge (one rising edge later).
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        drive(v.i);
        sb.push_back(v.e);
        @(negedge CLK);
        e = sb.pop_front();
        compare(tag, e);
    endtask

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    initial begin
        logic [INSTR_W-1:0] rd;
        in_t idle_in;
        idle_in = mi(F, F, F, 19'h0, F, F, F, 19'h0);

        //             start hr  ack rdata       done jr  dh  target
        //             state  req xs  lr  inc sel ir         pc_in_addr cnt
        // Back-to-back instructions, immediate ack and done.
        tbl[0]  = mv(mi(T, F, F, 19'h0,     F, F, F, 19'h0),
                     me(S_CLR, F, F, F, F, SP, 19'h0,     19'h0,     32'd0));
        tbl[1]  = mv(idle_in,
                     me(S_FET, T, F, F, F, SN, 19'h0,     19'h0,     32'd0));
        tbl[2]  = mv(mi(F, F, T, 19'h00011, F, F, F, 19'h0),
                     me(S_EXE, F, T, F, F, SN, 19'h00011, 19'h0,     32'd0));
        tbl[3]  = mv(mi(F, F, F, 19'h0,     T, F, F, 19'h0),
                     me(S_UPD, F, F, F, T, SP, 19'h00011, 19'h0,     32'd0));
        tbl[4]  = mv(idle_in,
                     me(S_FET, T, F, F, F, SN, 19'h00011, 19'h0,     32'd1));
        tbl[5]  = mv(mi(F, F, T, 19'h00022, F, F, F, 19'h0),
                     me(S_EXE, F, T, F, F, SN, 19'h00022, 19'h0,     32'd1));
        tbl[6]  = mv(mi(F, F, F, 19'h0,     T, F, F, 19'h0),
                     me(S_UPD, F, F, F, T, SP, 19'h00022, 19'h0,     32'd1));
        tbl[7]  = mv(idle_in,
                     me(S_FET, T, F, F, F, SN, 19'h00022, 19'h0,     32'd2));
        // Ack delayed four cycles; data present early must not be latched.
        tbl[8]  = mv(mi(F, F, F, 19'h5A5A5, F, F, F, 19'h0),
                     me(S_FET, T, F, F, F, SN, 19'h00022, 19'h0,     32'd2));
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = tbl[8];
        tbl[12] = mv(mi(F, F, T, 19'h5A5A5, F, F, F, 19'h0),
                     me(S_EXE, F, T, F, F, SN, 19'h5A5A5, 19'h0,     32'd2));
        // Jump without exec_done is ignored; with exec_done it loads.
        tbl[13] = mv(mi(F, F, F, 19'h0,     F, T, F, 19'h7FFFF),
                     me(S_EXE, F, F, F, F, SN, 19'h5A5A5, 19'h0,     32'd2));
        tbl[14] = mv(mi(F, F, F, 19'h0,     T, T, F, 19'h01234),
                     me(S_UPD, F, F, T, F, SP, 19'h5A5A5, 19'h01234, 32'd2));
        // start and halt_req outside their windows are ignored.
        tbl[15] = mv(mi(T, T, F, 19'h0,     F, F, F, 19'h0),
                     me(S_FET, T, F, F, F, SN, 19'h5A5A5, 19'h01234, 32'd3));
        tbl[16] = mv(mi(F, F, T, 19'h00033, F, F, F, 19'h0),
                     me(S_EXE, F, T, F, F, SN, 19'h00033, 19'h01234, 32'd3));
        // Jump + halt together: halt wins, no PC command.
        tbl[17] = mv(mi(F, T, F, 19'h0,     T, T, F, 19'h00555),
                     me(S_HLT, F, F, F, F, SN, 19'h00033, 19'h01234, 32'd3));
        tbl[18] = mv(idle_in,
                     me(S_HLT, F, F, F, F, SN, 19'h00033, 19'h01234, 32'd3));
        // Restart from HALT.
        tbl[19] = mv(mi(T, F, F, 19'h0,     F, F, F, 19'h0),
                     me(S_CLR, F, F, F, F, SP, 19'h00033, 19'h01234, 32'd0));
        tbl[20] = mv(idle_in,
                     me(S_FET, T, F, F, F, SN, 19'h00033, 19'h01234, 32'd0));
        tbl[21] = mv(mi(F, F, T, 19'h00044, F, F, F, 19'h0),
                     me(S_EXE, F, T, F, F, SN, 19'h00044, 19'h01234, 32'd0));
        // Decoded HALT instruction.
        tbl[22] = mv(mi(F, F, F, 19'h0,     T, F, T, 19'h0),
                     me(S_HLT, F, F, F, F, SN, 19'h00044, 19'h01234, 32'd0));
        // Stray ack / halt_req while halted change nothing.
        tbl[23] = mv(mi(F, T, T, 19'h77777, F, F, F, 19'h0),
                     me(S_HLT, F, F, F, F, SN, 19'h00044, 19'h01234, 32'd0));

        // Reset state.
        drive(idle_in);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        compare("reset", me(S_IDLE, F, F, F, F, SN, 19'h0, 19'h0, 32'd0));
        RESET_N = 1'b1;

        // Table-driven vectors.
        for (int k = 0; k < 24; k++) begin
            apply(tbl[k], $sformatf("row%0d", k));
        end

        // Ten sequential instructions from HALT.
        apply(mv(mi(T, F, F, 19'h0, F, F, F, 19'h0),
                 me(S_CLR, F, F, F, F, SP, 19'h00044, 19'h01234, 32'd0)), "seq.start");
        apply(mv(idle_in,
                 me(S_FET, T, F, F, F, SN, 19'h00044, 19'h01234, 32'd0)), "seq.fetch0");
        for (int k = 0; k < 10; k++) begin
            rd = 19'h00100 + 19'(k);
            apply(mv(mi(F, F, T, rd, F, F, F, 19'h0),
                     me(S_EXE, F, T, F, F, SN, rd, 19'h01234, 32'(k))),
                  $sformatf("seq%0d.exec", k));
            apply(mv(mi(F, F, F, 19'h0, T, F, F, 19'h0),
                     me(S_UPD, F, F, F, T, SP, rd, 19'h01234, 32'(k))),
                  $sformatf("seq%0d.update", k));
            apply(mv(idle_in,
                     me(S_FET, T, F, F, F, SN, rd, 19'h01234, 32'(k + 1))),
                  $sformatf("seq%0d.fetch", k));
        end
        check("ten_instr_count", 64'(instr_count), 64'(cnt_exp(32'd10)));

        // Asynchronous reset mid-FETCH, well away from any rising edge.
        check("pre_reset.imem_req", 64'(imem_req), 64'(T));
        #1 RESET_N = 1'b0;
        #1;
        compare("async_reset", me(S_IDLE, F, F, F, F, SN, 19'h0, 19'h0, 32'd0));
        @(negedge CLK);
        compare("held_reset", me(S_IDLE, F, F, F, F, SN, 19'h0, 19'h0, 32'd0));
        RESET_N = 1'b1;
        @(negedge CLK);
        compare("idle_after_reset", me(S_IDLE, F, F, F, F, SN, 19'h0, 19'h0, 32'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute sequencing FSM that drives the program counter's control inputs (LOAD_REG, INC_PC, LOAD_SELECT) and jump-target address.
- Handshakes with instruction memory and latches the fetched instruction word.
- Starts and stops execution units; decides per instruction between PC increment, PC load, PC clear, or halt.
- Sits between the control bus and the PC/IR/memory datapath of the 19-bit CPU.

Parameters:
ADDR_W, 19, PC/jump-target address width
INSTR_W, 19, instruction word width
SEL_W, 3, LOAD_SELECT width
SEL_PC, 3'd0, LOAD_SELECT code addressing the PC
SEL_NONE, 3'd7, LOAD_SELECT code addressing no register (PC holds)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
start  in  1  begin or restart execution (honoured in IDLE/HALT only)
halt_req  in  1  external halt, sampled at instruction boundary
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid
imem_rdata  in  INSTR_W  fetched instruction
ir  out  INSTR_W  latched instruction register
exec_start  out  1  one-cycle pulse, execution begins
exec_done  in  1  execution unit finished current instruction
jump_req  in  1  valid with exec_done: redirect PC
dec_halt  in  1  valid with exec_done: instruction is HALT
jump_target  in  ADDR_W  valid with exec_done
LOAD_REG  out  1  PC control: load enable
INC_PC  out  1  PC control: increment/clear select
LOAD_SELECT  out  SEL_W  PC control: register select
pc_in_address  out  ADDR_W  address presented to PC load input
state_dbg  out  3  current state encoding
instr_count  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Clocking/reset: one clock CLK; RESET_N is asynchronous and active-low. All outputs are registered (Moore).
- Reset values: state IDLE; imem_req=0, exec_start=0, LOAD_REG=0, INC_PC=0, LOAD_SELECT=SEL_NONE, pc_in_address=0, ir=0, instr_count=0.
- PC command encoding (asserted for exactly one cycle):
  - CLEAR = LOAD_REG 0, INC_PC 0, SEL_PC.
  - INCR = LOAD_REG 0, INC_PC 1, SEL_PC.
  - LOAD = LOAD_REG 1, INC_PC 0, SEL_PC.
  - All other cycles drive SEL_NONE, LOAD_REG=0, INC_PC=0, so the PC holds.
- States (state_dbg encoding):
  - IDLE(0): on start -> CLEAR.
  - CLEAR(1): drive CLEAR command; unconditionally -> FETCH.
  - FETCH(2): imem_req=1 held until imem_ack=1. On ack: ir<=imem_rdata, exec_start pulses next cycle, -> EXEC. No ack means wait indefinitely.
  - EXEC(3): exec_start=1 only on first cycle. Wait for exec_done. On exec_done, priority is:
    - halt_req or dec_halt -> HALT, no PC update.
    - else jump_req -> pc_in_address<=jump_target, -> UPDATE with LOAD.
    - else -> UPDATE with INCR.
  - UPDATE(4): drive the latched command; instr_count increments; -> FETCH.
  - HALT(5): all commands idle, imem_req=0; start -> CLEAR (restart from address 0).
- Boundary cases:
  - exec_done in the same cycle as exec_start is accepted.
  - jump_req/jump_target are ignored unless exec_done=1.
  - start outside IDLE/HALT is ignored.
  - halt_req outside EXEC is not latched.
- Latency: with ack in the first FETCH cycle and exec_done in the first EXEC cycle, one instruction takes 3 cycles (FETCH, EXEC, UPDATE). The PC holds its new value in the next FETCH cycle.
- Reset mid-operation: all outputs return to reset values asynchronously; an in-flight imem_req is dropped without waiting for ack.
- Width: jump_target is passed through unmodified; instr_count wraps 0xFFFFFFFF -> 0.

Optional Feature:
- Macro: PC_SEQ_INSTR_CNT_EN.
- Defined: instr_count increments by 1 in every UPDATE cycle. It clears on reset and on entry to CLEAR.
- Undefined: counter logic is omitted and instr_count is tied to 0.

Test Plan:
- Reset release, start=1 for one cycle, imem_ack immediate, exec_done immediate, no jump: CLEAR one cycle, then INCR every third cycle; state_dbg sequence 1,2,3,4,2...
- imem_ack delayed 4 cycles with imem_rdata=19'h5A5A5: imem_req held 5 cycles, ir=19'h5A5A5, exactly one exec_start pulse.
- exec_done with jump_req=1, jump_target=19'h01234: UPDATE cycle shows LOAD_REG=1, INC_PC=0, LOAD_SELECT=SEL_PC, pc_in_address=19'h01234.
- exec_done with jump_req=1 and halt_req=1 together: -> HALT, no LOAD/INCR issued; later start -> CLEAR command, fetch resumes.
- RESET_N low during FETCH with imem_req=1: imem_req=0 immediately, state_dbg=0, all PC commands idle.
- With PC_SEQ_INSTR_CNT_EN, 10 sequential instructions: instr_count=10. Without the macro, instr_count=0 throughout.
